rom_port_arbiter: RTL and testbench

Sequencing and sharing controller for the program ROM (2048 lines × 64 bits, synchronous read). Two 32-bit word-read ports are served from the single ROM read port: instruction fetch (IF) and data load (LD). Each port has a one-line (64-bit) buffer, so a second word in the same line returns without a ROM access. Misses are arbitrated round-robin, and a single ROM read can serve both ports when they target the same line. The block sits between the CPU core and the ROM macro.

---
 rtl/rom_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one synchronous 64-bit ROM read port between the
// IF and LD 32-bit word ports, each fronted by a one-line buffer.
module rom_port_arbiter #(
  parameter int LINES   = 2048,
  parameter int LINE_AW = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_ready,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  output logic               if_err,
  input  logic               ld_req,
  input  logic [31:0]        ld_addr,
  output logic               ld_ready,
  output logic               ld_rvalid,
  output logic [31:0]        ld_rdata,
  output logic               ld_err,
  output logic               rom_en,
  output logic [LINE_AW-1:0] rom_line_addr,
  input  logic [63:0]        rom_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FILL} state_t;

  localparam logic [28:0] LINES_TAG = 29'(LINES);

  // Port index 0 is IF, 1 is LD.
  logic [28:0]        atag [2];
  logic [1:0]         aword, req, accept, oor, hit, fill_done;
  logic [1:0]         pending_q, pending_d, valid_q, valid_d, word_q, word_d;
  logic [1:0]         rvalid_q, rvalid_d, err_q, err_d;
  logic [28:0]        tag_q [2], tag_d [2];
  logic [63:0]        linebuf_q [2], linebuf_d [2];
  logic [LINE_AW-1:0] line_q [2], line_d [2];
  logic [31:0]        rdata_q [2], rdata_d [2];
  state_t             state_q, state_d;
  logic               grant_q, grant_d, merge_q, merge_d, last_q, last_d;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], ld_addr[1:0]};

  always_comb begin
    atag[0] = if_addr[31:3];
    atag[1] = ld_addr[31:3];
    aword   = {ld_addr[2], if_addr[2]};
    req     = {ld_req, if_req};
    accept  = '0;
    oor     = '0;
    hit     = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      accept[p] = req[p] && !pending_q[p];
      oor[p]    = atag[p] >= LINES_TAG;
      // A request sampled at a flush edge never hits.
      hit[p]    = valid_q[p] && !flush && (tag_q[p] == atag[p]);
    end
  end

  assign fill_done = {(state_q == S_FILL) && (grant_q || merge_q),
                      (state_q == S_FILL) && (!grant_q || merge_q)};

  always_comb begin
    pending_d = pending_q;
    valid_d   = flush ? '0 : valid_q;
    word_d    = word_q;
    rvalid_d  = '0;
    err_d     = err_q;
    tag_d     = tag_q;
    linebuf_d = linebuf_q;
    line_d    = line_q;
    rdata_d   = rdata_q;
    state_d   = state_q;
    grant_d   = grant_q;
    merge_d   = merge_q;
    last_d    = last_q;

    for (int unsigned p = 0; p < 2; p++) begin
      if (fill_done[p]) begin
        pending_d[p] = 1'b0;
        rvalid_d[p]  = 1'b1;
        err_d[p]     = 1'b0;
        rdata_d[p]   = word_q[p] ? rom_rdata[63:32] : rom_rdata[31:0];
        linebuf_d[p] = rom_rdata;
        tag_d[p]     = 29'(line_q[p]);
        if (!flush) valid_d[p] = 1'b1;
      end else if (accept[p]) begin
        if (oor[p]) begin
          rvalid_d[p] = 1'b1;
          err_d[p]    = 1'b1;
          rdata_d[p]  = '0;
        end else if (hit[p]) begin
          rvalid_d[p] = 1'b1;
          err_d[p]    = 1'b0;
          rdata_d[p]  = aword[p] ? linebuf_q[p][63:32] : linebuf_q[p][31:0];
        end else begin
          pending_d[p] = 1'b1;
          line_d[p]    = atag[p][LINE_AW-1:0];
          word_d[p]    = aword[p];
        end
      end
    end

    // Grant sees misses accepted at this very edge; only contended grants
    // move the round-robin pointer.
    case (state_q)
      S_IDLE, S_FILL: begin
        state_d = S_IDLE;
        if (|pending_d) begin
          state_d = S_FETCH;
          merge_d = 1'b0;
          if (&pending_d) begin
            grant_d = ~last_q;
            last_d  = ~last_q;
            merge_d = (line_d[0] == line_d[1]);
          end else begin
            grant_d = pending_d[1];
          end
        end
      end
      S_FETCH: state_d = S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      merge_q   <= 1'b0;
      last_q    <= 1'b0;
      pending_q <= '0;
      valid_q   <= '0;
      word_q    <= '0;
      rvalid_q  <= '0;
      err_q     <= '0;
      tag_q     <= '{default: '0};
      linebuf_q <= '{default: '0};
      line_q    <= '{default: '0};
      rdata_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      merge_q   <= merge_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      word_q    <= word_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      tag_q     <= tag_d;
      linebuf_q <= linebuf_d;
      line_q    <= line_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rom_en        = (state_q == S_FETCH);
  assign rom_line_addr = rom_en ? (grant_q ? line_q[1] : line_q[0]) : '0;

  assign if_ready  = !pending_q[0];
  assign if_rvalid = rvalid_q[0];
  assign if_rdata  = rdata_q[0];
  assign if_err    = err_q[0];
  assign ld_ready  = !pending_q[1];
  assign ld_rvalid = rvalid_q[1];
  assign ld_rdata  = rdata_q[1];
  assign ld_err    = err_q[1];

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of both ports and their line buffers.
module tb_rom_port_arbiter;
  logic        clk, rst_n, flush;
  logic        if_req, ld_req;
  logic [31:0] if_addr, ld_addr;
  logic        if_ready, if_rvalid, if_err, ld_ready, ld_rvalid, ld_err;
  logic [31:0] if_rdata, ld_rdata;
  logic        rom_en;
  logic [10:0] rom_line_addr;
  logic [63:0] rom_rdata = '0;
  int unsigned rom_cnt = 0;
  int          total = 0;
  int          bad = 0;

  rom_port_arbiter #(.LINES(2048), .LINE_AW(11)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_en(rom_en), .rom_line_addr(rom_line_addr), .rom_rdata(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wexp(int unsigned line, int unsigned w);
    return 32'h1000_0000 + 32'(2 * line + w);
  endfunction

  // Synchronous ROM: line L holds {base+2L+1, base+2L}.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_rdata <= {wexp(32'(rom_line_addr), 1), wexp(32'(rom_line_addr), 0)};
      rom_cnt   <= rom_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
    tick();
    total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL rst_rom_en got=%b exp=0", rom_en); end
    total++; if (rom_line_addr !== 11'd0) begin bad++; $display("FAIL rst_line got=%0d exp=0", rom_line_addr); end
    total++; if ({if_rvalid, ld_rvalid, if_err, ld_err} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {if_rvalid, ld_rvalid, if_err, ld_err}); end
    total++; if ({if_rdata, ld_rdata} !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {if_rdata, ld_rdata}); end
    total++; if ({if_ready, ld_ready} !== 2'b11) begin bad++; $display("FAIL rst_ready got=%b exp=11", {if_ready, ld_ready}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_miss_latency();
    if_req = 1'b1; if_addr = 32'h10;
    tick(); if_req = 1'b0;
    total++; if (rom_en !== 1'b1 || rom_line_addr !== 11'd2) begin bad++; $display("FAIL miss_fetch got=%b/%0d exp=1/2", rom_en, rom_line_addr); end
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL miss_ready_c1 got=%b exp=0", if_ready); end
    tick();
    total++; if (if_ready !== 1'b0 || if_rvalid !== 1'b0) begin bad++; $display("FAIL miss_c2 ready/rvalid got=%b/%b exp=0/0", if_ready, if_rvalid); end
    total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL miss_fill_rom_en got=%b exp=0", rom_en); end
    tick();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0004 || if_err !== 1'b0) begin bad++; $display("FAIL miss_resp got=%b/%h/%b exp=1/10000004/0", if_rvalid, if_rdata, if_err); end
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL miss_ready_c3 got=%b exp=1", if_ready); end
  endtask

  task automatic test_hit();
    int unsigned c0;
    c0 = rom_cnt;
    if_req = 1'b1; if_addr = 32'h14;
    tick(); if_req = 1'b0;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0005) begin bad++; $display("FAIL hit_resp got=%b/%h exp=1/10000005", if_rvalid, if_rdata); end
    total++; if (rom_en !== 1'b0 || rom_cnt !== c0) begin bad++; $display("FAIL hit_no_rom got=%b/%0d exp=0/%0d", rom_en, rom_cnt, c0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if_req = 1'b1; if_addr = (i % 2 == 1) ? 32'h14 : 32'h10;
      tick();
      total++;
      if (if_rvalid !== 1'b1 || if_rdata !== wexp(2, i % 2)) begin
        bad++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, if_rvalid, if_rdata, wexp(2, i % 2));
      end
    end
    if_req = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    if_req = 1'b1; if_addr = 32'h48; ld_req = 1'b1; ld_addr = 32'h28;
    tick(); if_req = 1'b0; ld_req = 1'b0;
    total++; if (rom_en !== 1'b1 || rom_line_addr !== 11'd5) begin bad++; $display("FAIL tie1_first got=%b/%0d exp=1/5", rom_en, rom_line_addr); end
    tick(); tick();
    total++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h1000_000A || if_rvalid !== 1'b0) begin bad++; $display("FAIL tie1_ld got=%b/%h if=%b exp=1/1000000a if=0", ld_rvalid, ld_rdata, if_rvalid); end
    total++; if (rom_en !== 1'b1 || rom_line_addr !== 11'd9) begin bad++; $display("FAIL tie1_second got=%b/%0d exp=1/9", rom_en, rom_line_addr); end
    tick(); tick();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0012 || ld_rvalid !== 1'b0) begin bad++; $display("FAIL tie1_if got=%b/%h ld=%b exp=1/10000012 ld=0", if_rvalid, if_rdata, ld_rvalid); end
    if_req = 1'b1; if_addr = 32'h50; ld_req = 1'b1; ld_addr = 32'h30;
    tick(); if_req = 1'b0; ld_req = 1'b0;
    total++; if (rom_en !== 1'b1 || rom_line_addr !== 11'd10) begin bad++; $display("FAIL tie2_first got=%b/%0d exp=1/10", rom_en, rom_line_addr); end
    tick(); tick();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0014 || ld_rvalid !== 1'b0) begin bad++; $display("FAIL tie2_if got=%b/%h ld=%b exp=1/10000014 ld=0", if_rvalid, if_rdata, ld_rvalid); end
    tick(); tick();
    total++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h1000_000C) begin bad++; $display("FAIL tie2_ld got=%b/%h exp=1/1000000c", ld_rvalid, ld_rdata); end
  endtask

  task automatic test_merge();
    int unsigned c0;
    c0 = rom_cnt;
    if_req = 1'b1; if_addr = 32'h28; ld_req = 1'b1; ld_addr = 32'h2C;
    tick(); if_req = 1'b0; ld_req = 1'b0;
    total++; if (rom_en !== 1'b1 || rom_line_addr !== 11'd5) begin bad++; $display("FAIL merge_fetch got=%b/%0d exp=1/5", rom_en, rom_line_addr); end
    tick(); tick();
    total++; if (if_rvalid !== 1'b1 || ld_rvalid !== 1'b1) begin bad++; $display("FAIL merge_rvalid got=%b%b exp=11", if_rvalid, ld_rvalid); end
    total++; if (if_rdata !== 32'h1000_000A || ld_rdata !== 32'h1000_000B) begin bad++; $display("FAIL merge_data got=%h/%h exp=1000000a/1000000b", if_rdata, ld_rdata); end
    total++; if (rom_en !== 1'b0 || rom_cnt !== c0 + 1) begin bad++; $display("FAIL merge_single_rom got=%b/%0d exp=0/%0d", rom_en, rom_cnt, c0 + 1); end
  endtask

  task automatic test_oor();
    int unsigned c0;
    c0 = rom_cnt;
    ld_req = 1'b1; ld_addr = 32'h4000;
    tick(); ld_req = 1'b0;
    total++; if (ld_rvalid !== 1'b1 || ld_err !== 1'b1 || ld_rdata !== 32'd0) begin bad++; $display("FAIL oor_ld got=%b/%b/%h exp=1/1/0", ld_rvalid, ld_err, ld_rdata); end
    total++; if (rom_en !== 1'b0 || rom_cnt !== c0 || ld_ready !== 1'b1) begin bad++; $display("FAIL oor_no_rom got=%b/%0d/%b exp=0/%0d/1", rom_en, rom_cnt, ld_ready, c0); end
    if_req = 1'b1; if_addr = 32'hFFFF_FFF8;
    tick(); if_req = 1'b0;
    total++; if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'd0) begin bad++; $display("FAIL oor_if got=%b/%b/%h exp=1/1/0", if_rvalid, if_err, if_rdata); end
    ld_req = 1'b1; ld_addr = 32'h3FFC;
    tick(); ld_req = 1'b0;
    total++; if (rom_en !== 1'b1 || rom_line_addr !== 11'd2047) begin bad++; $display("FAIL last_line_fetch got=%b/%0d exp=1/2047", rom_en, rom_line_addr); end
    tick(); tick();
    total++; if (ld_rvalid !== 1'b1 || ld_err !== 1'b0 || ld_rdata !== 32'h1000_0FFF) begin bad++; $display("FAIL last_line_resp got=%b/%b/%h exp=1/0/10000fff", ld_rvalid, ld_err, ld_rdata); end
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h18;
    tick(); if_req = 1'b0;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0006) begin bad++; $display("FAIL flush_fill_resp got=%b/%h exp=1/10000006", if_rvalid, if_rdata); end
    if_req = 1'b1; if_addr = 32'h1C;
    tick(); if_req = 1'b0;
    total++; if (if_rvalid !== 1'b0 || rom_en !== 1'b1 || rom_line_addr !== 11'd3) begin bad++; $display("FAIL flush_remiss got=%b/%b/%0d exp=0/1/3", if_rvalid, rom_en, rom_line_addr); end
    tick(); tick();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0007) begin bad++; $display("FAIL flush_refill got=%b/%h exp=1/10000007", if_rvalid, if_rdata); end
  endtask

  task automatic test_reset_in_fetch();
    int seen;
    seen = 0;
    if_req = 1'b1; if_addr = 32'h20;
    tick(); if_req = 1'b0;
    total++; if (rom_en !== 1'b1) begin bad++; $display("FAIL rstf_in_fetch got=%b exp=1", rom_en); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (rom_en !== 1'b0 || rom_line_addr !== 11'd0 || if_ready !== 1'b1) begin bad++; $display("FAIL rstf_async got=%b/%0d/%b exp=0/0/1", rom_en, rom_line_addr, if_ready); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if_rvalid === 1'b1 || rom_en === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstf_dropped got=%0d activity cycles exp=0", seen); end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return $urandom | 32'h0000_4000;
    if (k == 1) return 32'h0000_4000 | ($urandom & 32'h7);
    if (k == 2) return 32'h0000_3FF8 | ($urandom & 32'h7);
    return (32'($urandom_range(0, 5)) << 3) | ($urandom & 32'h7);
  endfunction

  // Model: a port answers next cycle on out-of-range or on a buffered line,
  // otherwise within 2..6 cycles; its buffer holds the line of its last fill.
  task automatic test_random();
    logic [1:0]  req_v, outst, acc, imm, imm_err, bvalid, rv, er, rdy;
    logic        fl;
    logic [31:0] a [2], imm_data [2], exp_data [2], rd [2];
    int unsigned exp_line [2], bline [2], age [2], line, w;
    do_reset();
    req_v = '0; outst = '0; bvalid = '0; imm_err = '0;
    for (int p = 0; p < 2; p++) begin
      a[p] = '0; imm_data[p] = '0; exp_data[p] = '0; exp_line[p] = 0; bline[p] = 0; age[p] = 0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_v[p] && $urandom_range(0, 1) == 1) begin
          req_v[p] = 1'b1; a[p] = rand_addr();
        end
      end
      fl = ($urandom_range(0, 15) == 0);
      if_req = req_v[0]; if_addr = a[0]; ld_req = req_v[1]; ld_addr = a[1]; flush = fl;
      for (int p = 0; p < 2; p++) begin
        acc[p] = req_v[p] && !outst[p];
        imm[p] = 1'b0;
        if (acc[p]) begin
          line = 32'(a[p][31:3]); w = 32'(a[p][2]);
          if (line >= 2048) begin
            imm[p] = 1'b1; imm_err[p] = 1'b1; imm_data[p] = '0;
          end else if (bvalid[p] && bline[p] == line && !fl) begin
            imm[p] = 1'b1; imm_err[p] = 1'b0; imm_data[p] = wexp(line, w);
          end else begin
            exp_line[p] = line; exp_data[p] = wexp(line, w);
          end
        end
      end
      tick();
      rv = {ld_rvalid, if_rvalid}; er = {ld_err, if_err}; rdy = {ld_ready, if_ready};
      rd[0] = if_rdata; rd[1] = ld_rdata;
      if (fl) bvalid = '0;
      for (int p = 0; p < 2; p++) begin
        if (imm[p]) begin
          total++;
          if (rv[p] !== 1'b1 || rd[p] !== imm_data[p] || er[p] !== imm_err[p]) begin
            bad++; $display("FAIL rnd_imm p%0d cyc%0d got=%b/%h/%b exp=1/%h/%b", p, cyc, rv[p], rd[p], er[p], imm_data[p], imm_err[p]);
          end
        end else if (outst[p]) begin
          age[p]++;
          if (rv[p] === 1'b1) begin
            total++;
            if (rd[p] !== exp_data[p] || er[p] !== 1'b0 || age[p] < 2) begin
              bad++; $display("FAIL rnd_miss p%0d cyc%0d got=%h/%b age%0d exp=%h/0 age>=2", p, cyc, rd[p], er[p], age[p], exp_data[p]);
            end
            outst[p] = 1'b0; bline[p] = exp_line[p]; bvalid[p] = !fl;
          end else if (age[p] > 6) begin
            total++; bad++;
            $display("FAIL rnd_timeout p%0d cyc%0d got=no response exp=response by 6 cycles", p, cyc);
            outst[p] = 1'b0;
          end
        end else begin
          total++;
          if (rv[p] !== 1'b0) begin bad++; $display("FAIL rnd_spurious p%0d cyc%0d got=%b exp=0", p, cyc, rv[p]); end
        end
        if (acc[p]) begin
          req_v[p] = 1'b0;
          if (!imm[p]) begin outst[p] = 1'b1; age[p] = 0; end
        end
        total++;
        if (rdy[p] !== !outst[p]) begin bad++; $display("FAIL rnd_ready p%0d cyc%0d got=%b exp=%b", p, cyc, rdy[p], !outst[p]); end
      end
    end
    if_req = 1'b0; ld_req = 1'b0; flush = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_miss_latency();
    test_hit();
    test_back_to_back();
    test_tie();
    test_merge();
    test_oor();
    test_flush();
    test_reset_in_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
